// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: requester handshake and CDB broadcast bundle for the CDB arbiter
interface cdb_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int NAME_W = 5,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) ();
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*NAME_W-1:0] req_name;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ*TAG_W-1:0]  req_tag;
  logic [NREQ-1:0]        req_ready;
  logic                   cdb_en;
  logic [NAME_W-1:0]      cdb_name;
  logic [DATA_W-1:0]      cdb_data;
  logic [TAG_W-1:0]       cdb_tag;
  modport master (
    output req_valid, req_name, req_data, req_tag,
    input  req_ready, cdb_en, cdb_name, cdb_data, cdb_tag
  );
  modport slave (
    input  req_valid, req_name, req_data, req_tag,
    output req_ready, cdb_en, cdb_name, cdb_data, cdb_tag
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter driving the registered single-port CDB broadcast
module cdb_arbiter #(
  parameter int                NREQ     = 4,
  parameter int                NAME_W   = 5,
  parameter int                DATA_W   = 32,
  parameter int                TAG_W    = 4,
  parameter logic [TAG_W-1:0]  TAG_FREE = {TAG_W{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0]     ptr_q, ptr_d, gidx;
  logic              hit, xfer;
  logic [NREQ-1:0]   ready;
  int                j;
  logic              en_q, en_d;
  logic [NAME_W-1:0] name_q, name_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  // grant the first valid requester at or above ptr, wrapping; ready depends only on valid/ptr/flush/rst
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    j    = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (!hit && bus.req_valid[j]) begin
        hit  = 1'b1;
        gidx = PW'(j);
      end
    end
    ready = (hit && !rst && !flush) ? NREQ'(1) << gidx : '0;
  end
  assign bus.req_ready = ready;
  assign xfer = |(ready & bus.req_valid);
  // a transfer loads the winner's payload and advances ptr past it; otherwise broadcast idles
  always_comb begin
    ptr_d  = xfer ? (gidx == PW'(NREQ - 1) ? '0 : gidx + 1'b1) : ptr_q;
    en_d   = xfer;
    name_d = xfer ? bus.req_name[gidx*NAME_W +: NAME_W] : '0;
    data_d = xfer ? bus.req_data[gidx*DATA_W +: DATA_W] : '0;
    tag_d  = xfer ? bus.req_tag[gidx*TAG_W +: TAG_W] : TAG_FREE;
  end
  // pointer and broadcast register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      en_q   <= 1'b0;
      name_q <= '0;
      data_q <= '0;
      tag_q  <= TAG_FREE;
    end else begin
      ptr_q  <= ptr_d;
      en_q   <= en_d;
      name_q <= name_d;
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end
  assign bus.cdb_en   = en_q;
  assign bus.cdb_name = name_q;
  assign bus.cdb_data = data_q;
  assign bus.cdb_tag  = tag_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed-vector bench for the CDB round-robin arbiter
module tb_cdb_arbiter;
  localparam int NREQ = 4, NAME_W = 5, DATA_W = 32, TAG_W = 4;
  logic clk = 1'b0;
  logic rst, flush;
  int   nvec = 0, nbad = 0;
  cdb_arbiter_if #(.NREQ(NREQ), .NAME_W(NAME_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();
  cdb_arbiter #(.NREQ(NREQ), .NAME_W(NAME_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [NAME_W-1:0] n, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
    bus.req_name[i*NAME_W +: NAME_W] = n;
    bus.req_data[i*DATA_W +: DATA_W] = d;
    bus.req_tag[i*TAG_W +: TAG_W]    = t;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_en"},   64'(bus.cdb_en), 64'd0);
    chk({tag, "_name"}, 64'(bus.cdb_name), 64'd0);
    chk({tag, "_data"}, 64'(bus.cdb_data), 64'd0);
    chk({tag, "_tag"},  64'(bus.cdb_tag), 64'hF);
  endtask
  task automatic chk_bc(input string tag, input int n, input logic [31:0] d, input int t);
    chk({tag, "_en"},   64'(bus.cdb_en), 64'd1);
    chk({tag, "_name"}, 64'(bus.cdb_name), 64'(n));
    chk({tag, "_data"}, 64'(bus.cdb_data), 64'(d));
    chk({tag, "_tag"},  64'(bus.cdb_tag), 64'(t));
  endtask
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_req(i, NAME_W'(10 + i), 32'h1000 + 32'(i), TAG_W'(i));
    #1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk_idle("rst");
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_ready", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk_bc("rr", 10 + k % 4, 32'h1000 + 32'(k % 4), k % 4);
    end
    bus.req_valid = 4'b0100;
    #1;
    chk("wrap_pre_ready", 64'(bus.req_ready), 64'b0100);
    tick();
    chk_bc("wrap_pre", 12, 32'h1002, 2);
    bus.req_valid = 4'b1001;
    #1;
    chk("wrap3_ready", 64'(bus.req_ready), 64'b1000);
    tick();
    chk_bc("wrap3", 13, 32'h1003, 3);
    bus.req_valid = 4'b0001;
    #1;
    chk("wrap0_ready", 64'(bus.req_ready), 64'b0001);
    tick();
    chk_bc("wrap0", 10, 32'h1000, 0);
    bus.req_valid = 4'b0000;
    #1;
    chk("idle_ready", 64'(bus.req_ready), 64'd0);
    tick();
    chk_idle("idle");
    bus.req_valid = 4'b0010;
    set_req(1, 5, 32'hDEADBEEF, 3);
    #1;
    chk("single_ready", 64'(bus.req_ready), 64'b0010);
    tick();
    chk_bc("single", 5, 32'hDEADBEEF, 3);
    bus.req_valid = 4'b0000;
    tick();
    chk_idle("single_after");
    bus.req_valid = 4'b1000;
    #1;
    chk("pre_flush_ready", 64'(bus.req_ready), 64'b1000);
    tick();
    bus.req_valid = 4'b0101;
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(bus.req_ready), 64'd0);
    chk_bc("flush_inflight", 13, 32'h1003, 3);
    tick();
    chk_idle("flush_next");
    flush = 1'b0;
    #1;
    chk("post_flush_ready", 64'(bus.req_ready), 64'b0001);
    tick();
    chk_bc("post_flush", 10, 32'h1000, 0);
    bus.req_valid = 4'b0100;
    set_req(2, 0, 32'h0000_0055, 7);
    #1;
    chk("x0_ready", 64'(bus.req_ready), 64'b0100);
    tick();
    chk_bc("x0", 0, 32'h55, 7);
    bus.req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    chk("midrst_ready", 64'(bus.req_ready), 64'd0);
    tick();
    chk_idle("midrst");
    rst = 1'b0;
    #1;
    chk("midrst_ptr_ready", 64'(bus.req_ready), 64'b0001);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single Common Data Bus (CDB) write port among the functional units: ALU, load/store, branch and spare. It selects one completed result per cycle and drives the registered CDB broadcast. The register file and reservation stations consume the same broadcast (`enCDBWrt`, `CDBwrtName`, `CDBwrtData`, `CDBwrtTag`). Unselected requesters are back-pressured by a valid/ready handshake until granted.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `NAME_W`, 5, architectural register name width
- `DATA_W`, 32, result data width
- `TAG_W`, 4, rename tag width
- `TAG_FREE`, all-ones of `TAG_W`, tag value meaning "no producer"

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  misprediction flush: drop all pending and in-flight broadcasts
- `req_valid`  in  NREQ  requester i holds a completed result
- `req_name`  in  NREQ*NAME_W  destination register, requester i at slice [i*NAME_W +: NAME_W]
- `req_data`  in  NREQ*DATA_W  result data, same packing
- `req_tag`  in  NREQ*TAG_W  producer tag, same packing
- `req_ready`  out  NREQ  one-hot grant; transfer occurs when `req_valid[i] & req_ready[i]` at posedge
- `cdb_en`  out  1  broadcast valid (to regfile `enCDBWrt` and the reservation stations)
- `cdb_name`  out  NAME_W  broadcast destination
- `cdb_data`  out  DATA_W  broadcast data
- `cdb_tag`  out  TAG_W  broadcast tag

## Operation
- State: round-robin pointer `ptr` (log2 NREQ bits) and the output register (en, name, data, tag).
- Grant: search requesters starting at `ptr`, going upward mod NREQ. The first i with `req_valid[i]=1` gets `req_ready[i]=1`; all other ready bits are 0.
- No requester valid: `req_ready` is all 0.
- On a transfer from requester g:
  - the output register loads that requester's name, data and tag, with en=1;
  - `ptr` <= (g+1) mod NREQ.
- No transfer: en <= 0, name <= 0, data <= 0, tag <= `TAG_FREE`; `ptr` holds.
- Requester rules:
  - must hold valid and payload stable until ready;
  - may not drop valid without a transfer, except on flush.
- `name` = 0 (x0) is broadcast unchanged. The regfile ignores the data, but the tag must still wake the reservation stations.
- `flush`=1:
  - `req_ready` forced all 0, so no transfer;
  - output register cleared to the idle values next edge;
  - `ptr` holds.
- Fairness: a continuously valid requester is granted within NREQ accepted transfers.

## Timing
- Reset values: `cdb_en`=0, `cdb_name`=0, `cdb_data`=0, `cdb_tag`=`TAG_FREE`, `ptr`=0. `req_ready` is all 0 while `rst`=1.
- `req_ready` is combinational from `req_valid`, `ptr`, `flush` and `rst` only. It never depends on the payload.
- Latency: transfer at edge k means `cdb_*` is valid during cycle k+1, for exactly one cycle unless another transfer occurred at edge k+1.
- Throughput: one broadcast per cycle. Back-to-back grants produce continuous `cdb_en`=1.
- Flush in the same cycle as an otherwise-valid grant: no transfer; the requester still holds unless it is itself flushed.
- Flush while `cdb_en`=1: the current broadcast completes this cycle; next cycle is idle.
- `rst` mid-stream: pending requests are not accepted and the output returns to reset values at the next edge.

## Test plan
- Reset: assert `rst` 2 cycles with all `req_valid`=1. Required: `req_ready`=0, `cdb_en`=0, `cdb_tag`=`TAG_FREE`.
- Single request: requester 1 presents name=5, data=0xDEADBEEF, tag=3 at cycle 0. Required: `req_ready`=0010 in cycle 0; cycle 1 shows `cdb_en`=1, name=5, data=0xDEADBEEF, tag=3; cycle 2 shows `cdb_en`=0.
- Round-robin: all 4 requesters valid continuously from reset. Required: grant order 0,1,2,3,0; `cdb_en`=1 every cycle from cycle 1.
- Pointer wrap: `ptr`=3 after granting 2; only requesters 0 and 3 valid. Required: 3 granted, then 0.
- Flush: requesters 0 and 2 valid and `flush`=1 for one cycle. Required: `req_ready`=0 that cycle and `cdb_en`=0 the next; after flush drops, requester 0 is granted if `ptr`=0.
- x0 result: name=0, tag=7 from requester 2. Required: broadcast with `cdb_en`=1, name=0, tag=7.
